router_pkt_reg: RTL and testbench

ROUTER_PKT_REG -- requirements
Module: router_pkt_reg

---
 rtl/router_pkt_reg.sv | 176 +++++++++++++++++
 tb/tb_router_pkt_reg.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_reg.sv
// Packet register stage: moves header/payload/check bytes into a destination FIFO.
// Ports: clock/reset, pkt_valid/data_in/fifo_full in; dout/write_enb/dest/busy/parity_done/err/len_err out.
module router_pkt_reg #(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 3,
  parameter int ADDR_W     = 2,
  parameter int CHECK_MODE = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  output logic [DATA_W-1:0] dout,
  output logic              write_enb,
  output logic [ADDR_W-1:0] dest,
  output logic              busy,
  output logic              parity_done,
  output logic              err,
  output logic              len_err
);

  localparam int LEN_W = DATA_W - ADDR_W;
  localparam logic [ADDR_W:0] NCH = NUM_CH[ADDR_W:0];

  typedef enum logic [2:0] {
    IDLE,
    LOAD_FIRST,
    LOAD_DATA,
    HOLD,
    CHECK,
    DROP
  } state_t;

  state_t state, n_state;

  logic [DATA_W-1:0] hdr, n_hdr;
  logic [LEN_W-1:0]  len, n_len;
  logic [DATA_W-1:0] acc, n_acc;
  logic [LEN_W-1:0]  cnt, n_cnt;
  logic [DATA_W-1:0] pkt_check, n_chk;
  logic [DATA_W-1:0] hold, n_hold;
  logic              hold_chk, n_hchk;
  logic [DATA_W-1:0] n_dout;
  logic              n_we;
  logic [ADDR_W-1:0] n_dest;
  logic              n_pd, n_err, n_lerr;

  function automatic logic [DATA_W-1:0] step(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    if (CHECK_MODE == 1) return a + b;
    return a ^ b;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= n_state;
  end

  always_comb begin
    n_state = state;
    n_hdr   = hdr;
    n_len   = len;
    n_acc   = acc;
    n_cnt   = cnt;
    n_chk   = pkt_check;
    n_hold  = hold;
    n_hchk  = hold_chk;
    n_dout  = dout;
    n_we    = 1'b0;
    n_dest  = dest;
    n_pd    = parity_done;
    n_err   = err;
    n_lerr  = len_err;
    busy    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pkt_valid) begin
          n_hdr  = data_in;
          n_dest = data_in[ADDR_W-1:0];
          n_len  = data_in[DATA_W-1:ADDR_W];
          n_acc  = '0;
          n_cnt  = '0;
          n_pd   = 1'b0;
          n_err  = 1'b0;
          n_lerr = 1'b0;
          if ({1'b0, data_in[ADDR_W-1:0]} < NCH)
            n_state = LOAD_FIRST;
          else
            n_state = DROP;
        end
      end
      LOAD_FIRST: begin
        busy = 1'b1;
        if (!fifo_full) begin
          n_dout  = hdr;
          n_we    = 1'b1;
          n_acc   = step(acc, hdr);
          n_state = LOAD_DATA;
        end
      end
      LOAD_DATA: begin
        if (pkt_valid) begin
          n_acc = step(acc, data_in);
          n_cnt = (&cnt) ? cnt : cnt + 1'b1;
        end else begin
          n_chk = data_in;
        end
        // A blocked byte is parked so the source can move on.
        if (fifo_full) begin
          n_hold  = data_in;
          n_hchk  = !pkt_valid;
          n_state = HOLD;
        end else begin
          n_dout  = data_in;
          n_we    = 1'b1;
          n_state = pkt_valid ? LOAD_DATA : CHECK;
        end
      end
      HOLD: begin
        busy = 1'b1;
        if (!fifo_full) begin
          n_dout  = hold;
          n_we    = 1'b1;
          n_state = hold_chk ? CHECK : LOAD_DATA;
        end
      end
      CHECK: begin
        busy    = 1'b1;
        n_pd    = 1'b1;
        n_err   = (pkt_check != acc);
        n_lerr  = (cnt != len);
        n_state = IDLE;
      end
      DROP: begin
        if (!pkt_valid) n_state = IDLE;
      end
      default: n_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hdr         <= '0;
      len         <= '0;
      acc         <= '0;
      cnt         <= '0;
      pkt_check   <= '0;
      hold        <= '0;
      hold_chk    <= 1'b0;
      dout        <= '0;
      write_enb   <= 1'b0;
      dest        <= '0;
      parity_done <= 1'b0;
      err         <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      hdr         <= n_hdr;
      len         <= n_len;
      acc         <= n_acc;
      cnt         <= n_cnt;
      pkt_check   <= n_chk;
      hold        <= n_hold;
      hold_chk    <= n_hchk;
      dout        <= n_dout;
      write_enb   <= n_we;
      dest        <= n_dest;
      parity_done <= n_pd;
      err         <= n_err;
      len_err     <= n_lerr;
    end
  end

endmodule

// File: tb/tb_router_pkt_reg.sv
// Bench for router_pkt_reg: XOR and checksum instances share one stimulus stream.
// Scoreboard queues hold expected FIFO writes and per-packet status.
module tb_router_pkt_reg;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pkt_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       fifo_full = 1'b0;

  logic [7:0] dout0, dout1;
  logic       we0, we1;
  logic [1:0] dest0, dest1;
  logic       busy0, busy1;
  logic       pd0, pd1;
  logic       err0, err1;
  logic       le0, le1;

  router_pkt_reg #(.DATA_W(8), .NUM_CH(3), .ADDR_W(2), .CHECK_MODE(0)) u0 (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid),
    .data_in(data_in), .fifo_full(fifo_full),
    .dout(dout0), .write_enb(we0), .dest(dest0), .busy(busy0),
    .parity_done(pd0), .err(err0), .len_err(le0)
  );

  router_pkt_reg #(.DATA_W(8), .NUM_CH(3), .ADDR_W(2), .CHECK_MODE(1)) u1 (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid),
    .data_in(data_in), .fifo_full(fifo_full),
    .dout(dout1), .write_enb(we1), .dest(dest1), .busy(busy1),
    .parity_done(pd1), .err(err1), .len_err(le1)
  );

  always #5 clock = ~clock;

  typedef struct { logic [7:0] b; logic [1:0] d; } wr_t;
  typedef struct { logic e0; logic e1; logic le; } st_t;

  wr_t wq[$];
  st_t sq[$];

  int checks = 0;
  int errors = 0;
  logic pd_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (we0) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", {24'h0, dout0}, 32'hffff_ffff);
        end else begin
          chk("dout", dout0, wq[0].b);
          chk("dest", dest0, wq[0].d);
          chk("we_m1", we1, 1'b1);
          chk("dout_m1", dout1, wq[0].b);
          void'(wq.pop_front());
        end
      end
      if (pd0 && !pd_prev) begin
        if (sq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          chk("err_m0", err0, sq[0].e0);
          chk("err_m1", err1, sq[0].e1);
          chk("len_err", le0, sq[0].le);
          chk("done_m1", pd1, 1'b1);
          void'(sq.pop_front());
        end
      end
    end
    pd_prev <= pd0;
  end

  task automatic zchk(input string tag);
    chk({tag, "_dout"}, dout0, 0);
    chk({tag, "_we"}, we0, 0);
    chk({tag, "_dest"}, dest0, 0);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_pd"}, pd0, 0);
    chk({tag, "_err"}, err0, 0);
    chk({tag, "_le"}, le0, 0);
    chk({tag, "_we_m1"}, we1, 0);
    chk({tag, "_pd_m1"}, pd1, 0);
  endtask

  // cs: 0 = use cval, 1 = correct XOR, 2 = correct sum, 3 = random
  // ffm: 0 = never full, 1 = random full, 2 = full 3 cycles on byte 2
  task automatic send(input logic [1:0] addr, input int lenf,
                      input int npay, input bit fixed, input int cs,
                      input logic [7:0] cval, input int ffm,
                      input int abort_i);
    logic [7:0] bytes[$];
    logic [7:0] h, x, s, c, pb;
    logic [5:0] lf;
    int i, n, cyc, ff_left, hold_cyc;
    bit b, fired;
    lf = lenf[5:0];
    h = {lf, addr};
    bytes.push_back(h);
    for (int k = 0; k < npay; k++) begin
      pb = fixed ? 8'(8'h11 * (k + 1)) : 8'($urandom_range(0, 255));
      bytes.push_back(pb);
    end
    x = 8'h00;
    s = 8'h00;
    foreach (bytes[k]) begin
      x = x ^ bytes[k];
      s = s + bytes[k];
    end
    case (cs)
      1: c = x;
      2: c = s;
      3: c = 8'($urandom_range(0, 255));
      default: c = cval;
    endcase
    bytes.push_back(c);
    n = bytes.size();
    if (addr < 2'd3) begin
      foreach (bytes[k]) wq.push_back('{b: bytes[k], d: addr});
      sq.push_back('{e0: (c != x), e1: (c != s),
                     le: (((npay > 63) ? 63 : npay) != lenf)});
    end
    i = 0;
    cyc = 0;
    ff_left = 0;
    hold_cyc = 0;
    fired = 0;
    while (i < n) begin
      @(negedge clock);
      data_in = bytes[i];
      pkt_valid = (i < n - 1);
      if (ffm == 2 && i == 2 && !fired) begin
        fired = 1;
        ff_left = 3;
      end
      if (ffm == 1) fifo_full = ($urandom_range(0, 9) < 3);
      else if (ff_left > 0) begin
        fifo_full = 1'b1;
        ff_left--;
      end else fifo_full = 1'b0;
      b = busy0;
      if (ffm == 2 && i == 3 && b) hold_cyc++;
      @(posedge clock);
      if (!b) i++;
      cyc++;
      if (abort_i > 0 && i == abort_i) begin
        #1 reset = 1'b1;
        #1 zchk("mid_reset");
        wq.delete();
        sq.delete();
        @(negedge clock);
        reset = 1'b0;
        pkt_valid = 1'b0;
        fifo_full = 1'b0;
        return;
      end
      if (cyc > 2000) begin
        chk("packet_timeout", cyc, 0);
        break;
      end
    end
    if (ffm == 2) chk("busy_hold_cycles", hold_cyc, 3);
  endtask

  task automatic gap(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clock);
      pkt_valid = 1'b0;
      fifo_full = 1'b0;
      data_in = 8'($urandom_range(0, 255));
    end
  endtask

  initial begin
    #1 zchk("reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    gap(2);

    send(2'd1, 3, 3, 1, 0, 8'h0D, 0, 0);
    gap(2);
    chk("dest_after", dest0, 2'd1);
    chk("done_after", pd0, 1'b1);
    send(2'd1, 3, 3, 1, 0, 8'h0C, 0, 0);
    gap(1);
    send(2'd1, 3, 3, 1, 0, 8'h73, 0, 0);
    gap(1);
    send(2'd1, 3, 3, 1, 0, 8'h0D, 2, 0);
    gap(2);

    send(2'd3, 1, 1, 0, 3, 8'h00, 0, 0);
    @(negedge clock);
    chk("drop_done", pd0, 1'b0);
    chk("drop_err", err0, 1'b0);
    chk("drop_dest", dest0, 2'd3);
    send(2'd1, 2, 3, 1, 1, 8'h00, 0, 0);
    gap(2);

    send(2'd1, 3, 3, 1, 1, 8'h00, 0, 3);
    gap(2);
    send(2'd1, 3, 3, 1, 0, 8'h0D, 0, 0);
    gap(2);

    for (int p = 0; p < 60; p++) begin
      int np, lf, cs, ffm;
      np = $urandom_range(0, 6);
      lf = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : np;
      cs = $urandom_range(1, 3);
      ffm = $urandom_range(0, 1);
      send(2'($urandom_range(0, 3)), lf, np, 0, cs, 8'h00, ffm, 0);
      gap($urandom_range(0, 2));
    end

    gap(20);
    chk("writes_drained", wq.size(), 0);
    chk("status_drained", sq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
